// File: rtl/magma_bus_pkg.sv
// Shared cluster bus definitions: field widths and the packed request payload
// used by the arbiter and the cluster slaves.
package magma_bus_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_BEW = 4;

  typedef struct packed {
    logic               we;
    logic [BUS_AW-1:0]  addr;
    logic [BUS_BEW-1:0] be;
    logic [BUS_DW-1:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/magma_bus_arb_if.sv
// Bundle of the multi-master request/response signals and the single slave
// port; the slave modport is the arbiter's view, master is the environment's.
interface magma_bus_arb_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  import magma_bus_pkg::*;

  logic [NUM_MASTERS-1:0]         m_req;
  logic [NUM_MASTERS-1:0]         m_we;
  logic [NUM_MASTERS*BUS_AW-1:0]  m_addr;
  logic [NUM_MASTERS*BUS_BEW-1:0] m_be;
  logic [NUM_MASTERS*BUS_DW-1:0]  m_wdata;
  logic [NUM_MASTERS-1:0]         m_ack;
  logic [NUM_MASTERS-1:0]         m_resp;
  logic [BUS_DW-1:0]              m_rdata;

  logic                           s_req;
  logic                           s_we;
  logic [BUS_AW-1:0]              s_addr;
  logic [BUS_BEW-1:0]             s_be;
  logic [BUS_DW-1:0]              s_wdata;
  logic                           s_ack;
  logic                           s_resp;
  logic [BUS_DW-1:0]              s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_we, s_addr, s_be, s_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_rdata, s_req, s_we, s_addr, s_be, s_wdata
  );

endinterface

// File: rtl/magma_arb_idfifo.sv
// In-order FIFO of read-owner IDs; head is read straight from the storage
// registers so the response path needs no extra cycle.
module magma_arb_idfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/magma_bus_arb.sv
// Round-robin arbiter sharing one slave port among NUM_MASTERS masters, with
// in-order routing of read responses back to the issuing master.
module magma_bus_arb
  import magma_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  magma_bus_arb_if.slave  bus,
  output logic            err_o
);

  localparam int unsigned IDW = $clog2(NUM_MASTERS);
  localparam int unsigned SW  = IDW + 1;

  bus_req_t               w_req [NUM_MASTERS];
  bus_req_t               w_sel;
  logic [NUM_MASTERS-1:0] w_req_rot;
  logic [NUM_MASTERS-1:0] w_gnt;
  logic [IDW-1:0]         w_offs;
  logic [IDW-1:0]         w_gnt_idx;
  logic [SW-1:0]          w_sum;
  logic                   w_found;
  logic                   w_s_req;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [IDW-1:0]         w_head;
  logic [IDW-1:0]         r_rr_ptr;
  logic                   r_err;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req[i].we    = bus.m_we[i];
      w_req[i].addr  = bus.m_addr[i*BUS_AW +: BUS_AW];
      w_req[i].be    = bus.m_be[i*BUS_BEW +: BUS_BEW];
      w_req[i].wdata = bus.m_wdata[i*BUS_DW +: BUS_DW];
    end
  end

  // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, un-rotate.
  always_comb begin
    w_req_rot = NUM_MASTERS'({bus.m_req, bus.m_req} >> r_rr_ptr);
    w_found   = 1'b0;
    w_offs    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_offs  = IDW'(i);
      end
    end
    w_sum = SW'(r_rr_ptr) + SW'(w_offs);
    if (w_sum >= SW'(NUM_MASTERS)) w_sum = w_sum - SW'(NUM_MASTERS);
    w_gnt_idx = w_sum[IDW-1:0];
    w_gnt     = w_found ? (NUM_MASTERS'(1) << w_gnt_idx) : '0;
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_gnt[i]) w_sel = w_req[i];
    end
  end

  // Full FIFO blocks every new request, writes included, to keep ordering simple.
  assign w_s_req     = (|bus.m_req) & ~w_full;
  assign w_accept    = w_s_req & bus.s_ack;
  assign w_push      = w_accept & ~w_sel.we;
  assign w_pop       = bus.s_resp & ~w_empty;

  assign bus.s_req   = w_s_req;
  assign bus.s_we    = w_sel.we;
  assign bus.s_addr  = w_sel.addr;
  assign bus.s_be    = w_sel.be;
  assign bus.s_wdata = w_sel.wdata;
  assign bus.m_ack   = w_accept ? w_gnt : '0;
  assign bus.m_resp  = w_pop ? (NUM_MASTERS'(1) << w_head) : '0;
  assign bus.m_rdata = w_pop ? bus.s_rdata : '0;
  assign err_o       = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == IDW'(NUM_MASTERS - 1)) ? '0 : w_gnt_idx + IDW'(1);
    end
  end

  // A response with nothing outstanding is a protocol error; sticky until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (bus.s_resp && w_empty) begin
      r_err <= 1'b1;
    end
  end

  magma_arb_idfifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_din   (w_gnt_idx),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_magma_bus_arb.sv
// Directed bench for magma_bus_arb: a queue-based reference model checked every
// cycle, plus hand-computed per-vector expectations.
module tb_magma_bus_arb;
  import magma_bus_pkg::*;

  localparam int NM = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  always #5 clk = ~clk;

  magma_bus_arb_if #(.NUM_MASTERS(NM)) bif();

  magma_bus_arb #(
    .NUM_MASTERS     (NM),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif),
    .err_o (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer as an integer, outstanding reads as a queue of owners.
  int          mdl_ptr = 0;
  int          mdl_q[$];
  bit          mdl_err = 1'b0;
  int          mdl_g;
  logic        e_sreq, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be, e_ack, e_resp;

  always @(negedge clk) begin
    if (rst) begin
      mdl_q.delete();
      mdl_ptr = 0;
      mdl_err = 1'b0;
      chk("model err_o in reset", 64'(err), 64'(0));
    end else begin
      mdl_g = -1;
      for (int k = 0; k < NM; k++)
        if (mdl_g < 0 && bif.m_req[(mdl_ptr + k) % NM]) mdl_g = (mdl_ptr + k) % NM;
      e_sreq = (bif.m_req != 0) && (mdl_q.size() < MO);
      e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
      if (mdl_g >= 0) begin
        e_we    = bif.m_we[mdl_g];
        e_addr  = bif.m_addr[mdl_g*32 +: 32];
        e_be    = bif.m_be[mdl_g*4 +: 4];
        e_wdata = bif.m_wdata[mdl_g*32 +: 32];
      end
      e_ack  = (e_sreq && bif.s_ack && mdl_g >= 0) ? 4'(1 << mdl_g) : 4'b0;
      e_resp = (bif.s_resp && mdl_q.size() > 0) ? 4'(1 << mdl_q[0]) : 4'b0;

      chk("model s_req",   64'(bif.s_req),   64'(e_sreq));
      chk("model s_we",    64'(bif.s_we),    64'(e_we));
      chk("model s_addr",  64'(bif.s_addr),  64'(e_addr));
      chk("model s_be",    64'(bif.s_be),    64'(e_be));
      chk("model s_wdata", 64'(bif.s_wdata), 64'(e_wdata));
      chk("model m_ack",   64'(bif.m_ack),   64'(e_ack));
      chk("model m_resp",  64'(bif.m_resp),  64'(e_resp));
      chk("model err_o",   64'(err),         64'(mdl_err));
      if (e_resp != 0) chk("model m_rdata", 64'(bif.m_rdata), 64'(bif.s_rdata));

      if (bif.s_resp) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else mdl_err = 1'b1;
      end
      if (e_ack != 0) begin
        mdl_ptr = (mdl_g + 1) % NM;
        if (!e_we) mdl_q.push_back(mdl_g);
      end
    end
  end

  // One cycle: drive at posedge+1, check hand-computed values at +3, advance.
  task automatic run_vec(input string nm, input logic [3:0] req, input logic [3:0] we,
                         input logic ack, input logic resp, input logic [31:0] rdata,
                         input logic [3:0] x_ack, input logic [3:0] x_resp,
                         input logic x_sreq, input logic x_err, input int x_ptr);
    bif.m_req   = req;
    bif.m_we    = we;
    bif.s_ack   = ack;
    bif.s_resp  = resp;
    bif.s_rdata = rdata;
    #2;
    chk({nm, " m_ack"},  64'(bif.m_ack),       64'(x_ack));
    chk({nm, " m_resp"}, 64'(bif.m_resp),      64'(x_resp));
    chk({nm, " s_req"},  64'(bif.s_req),       64'(x_sreq));
    chk({nm, " err_o"},  64'(err),             64'(x_err));
    chk({nm, " rr_ptr"}, 64'(dut.r_rr_ptr),    64'(x_ptr));
    if (x_resp != 0) chk({nm, " m_rdata"}, 64'(bif.m_rdata), 64'(rdata));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bif.m_req = '0; bif.m_we = '0; bif.s_ack = 1'b0; bif.s_resp = 1'b0; bif.s_rdata = '0;
    bif.m_addr  = {32'h0000_3000, 32'h0000_0010, 32'h0000_2000, 32'h0000_1000};
    bif.m_be    = {4'h1, 4'hC, 4'h3, 4'hF};
    bif.m_wdata = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset err_o",  64'(err),                  64'(0));
    chk("reset m_ack",  64'(bif.m_ack),            64'(0));
    chk("reset m_resp", 64'(bif.m_resp),           64'(0));
    chk("reset s_req",  64'(bif.s_req),            64'(0));
    chk("reset rr_ptr", 64'(dut.r_rr_ptr),         64'(0));
    chk("reset count",  64'(dut.u_idfifo.r_count), 64'(0));
    rst = 1'b0;

    // Single master read with response data routed back.
    run_vec("single acc",  4'b0100, 4'b0000, 1, 0, 32'h0,      4'b0100, 4'b0000, 1, 0, 0);
    run_vec("single idle", 4'b0000, 4'b0000, 0, 0, 32'h0,      4'b0000, 4'b0000, 0, 0, 3);
    run_vec("single resp", 4'b0000, 4'b0000, 0, 1, 32'hCAFE,   4'b0000, 4'b0100, 0, 0, 3);

    // Fairness: all masters writing continuously from a fresh pointer.
    do_reset();
    run_vec("rr0", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b0001, 4'b0000, 1, 0, 0);
    run_vec("rr1", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b0010, 4'b0000, 1, 0, 1);
    run_vec("rr2", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b0100, 4'b0000, 1, 0, 2);
    run_vec("rr3", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b1000, 4'b0000, 1, 0, 3);
    run_vec("rr4", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b0001, 4'b0000, 1, 0, 0);
    run_vec("rr5", 4'b1111, 4'b1111, 1, 0, 32'h0, 4'b0010, 4'b0000, 1, 0, 1);

    // Interleaved reads 3,1,0 answered three cycles after each ack.
    run_vec("ilv rd3",   4'b1000, 4'b0000, 1, 0, 32'h0,  4'b1000, 4'b0000, 1, 0, 2);
    run_vec("ilv rd1",   4'b0010, 4'b0000, 1, 0, 32'h0,  4'b0010, 4'b0000, 1, 0, 0);
    run_vec("ilv rd0",   4'b0001, 4'b0000, 1, 0, 32'h0,  4'b0001, 4'b0000, 1, 0, 2);
    run_vec("ilv resp3", 4'b0000, 4'b0000, 0, 1, 32'h33, 4'b0000, 4'b1000, 0, 0, 1);
    run_vec("ilv resp1", 4'b0000, 4'b0000, 0, 1, 32'h11, 4'b0000, 4'b0010, 0, 0, 1);
    run_vec("ilv resp0", 4'b0000, 4'b0000, 0, 1, 32'h00, 4'b0000, 4'b0001, 0, 0, 1);

    // Fill the FIFO; master 1 is blocked until the cycle after the first response.
    run_vec("full rd0a", 4'b0001, 4'b0000, 1, 0, 32'h0,  4'b0001, 4'b0000, 1, 0, 1);
    run_vec("full rd2",  4'b0100, 4'b0000, 1, 0, 32'h0,  4'b0100, 4'b0000, 1, 0, 1);
    run_vec("full rd3",  4'b1000, 4'b0000, 1, 0, 32'h0,  4'b1000, 4'b0000, 1, 0, 3);
    run_vec("full rd0b", 4'b0001, 4'b0000, 1, 0, 32'h0,  4'b0001, 4'b0000, 1, 0, 0);
    run_vec("full blk",  4'b0010, 4'b0000, 1, 0, 32'h0,  4'b0000, 4'b0000, 0, 0, 1);
    run_vec("full rsp",  4'b0010, 4'b0000, 1, 1, 32'h55, 4'b0000, 4'b0001, 0, 0, 1);
    run_vec("full rel",  4'b0010, 4'b0000, 1, 0, 32'h0,  4'b0010, 4'b0000, 1, 0, 1);
    run_vec("drain2",    4'b0000, 4'b0000, 0, 1, 32'h62, 4'b0000, 4'b0100, 0, 0, 2);
    run_vec("drain3",    4'b0000, 4'b0000, 0, 1, 32'h63, 4'b0000, 4'b1000, 0, 0, 2);
    run_vec("drain0",    4'b0000, 4'b0000, 0, 1, 32'h60, 4'b0000, 4'b0001, 0, 0, 2);
    run_vec("drain1",    4'b0000, 4'b0000, 0, 1, 32'h61, 4'b0000, 4'b0010, 0, 0, 2);

    // Stray response sets the sticky error; held request without s_ack keeps rr_ptr.
    run_vec("stray rsp", 4'b0000, 4'b0000, 0, 1, 32'hBAD, 4'b0000, 4'b0000, 0, 0, 2);
    run_vec("hold a",    4'b0100, 4'b0000, 0, 0, 32'h0,   4'b0000, 4'b0000, 1, 1, 2);
    run_vec("hold b",    4'b0100, 4'b0000, 0, 0, 32'h0,   4'b0000, 4'b0000, 1, 1, 2);

    // Two reads outstanding, then asynchronous reset in the middle of a cycle.
    run_vec("pre rd0",   4'b0001, 4'b0000, 1, 0, 32'h0,   4'b0001, 4'b0000, 1, 1, 2);
    run_vec("pre rd1",   4'b0010, 4'b0000, 1, 0, 32'h0,   4'b0010, 4'b0000, 1, 1, 1);
    bif.m_req = '0; bif.s_ack = 1'b0;
    chk("pre-rst count", 64'(dut.u_idfifo.r_count), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("async rst count",  64'(dut.u_idfifo.r_count), 64'(0));
    chk("async rst rr_ptr", 64'(dut.r_rr_ptr),         64'(0));
    chk("async rst err_o",  64'(err),                  64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // A late response for a pre-reset read finds the FIFO empty.
    run_vec("late rsp",  4'b0000, 4'b0000, 0, 1, 32'h77, 4'b0000, 4'b0000, 0, 0, 0);
    run_vec("late err",  4'b0000, 4'b0000, 0, 0, 32'h0,  4'b0000, 4'b0000, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/magma_bus_arb.md
# magma_bus_arb

Round-robin arbiter that shares one slave bus port (SFR block, local memory or peripheral) among NUM_MASTERS cores of the multicore cluster. It passes requests through combinationally under the slave's req/ack handshake. It records the owner of every accepted read in an in-order ID FIFO, and routes each later read response back to the master that issued it.

## Interface
- NUM_MASTERS, 4: number of requesting masters, range 2..8.
- MAX_OUTSTANDING, 4: depth of the read-owner FIFO, which is the maximum number of accepted reads not yet answered. Must be a power of two, at least 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- m_req  in  NUM_MASTERS  per-master request; held by the master until acked.
- m_we  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- m_addr  in  NUM_MASTERS*32  address, flattened; master i uses bits [i*32 +: 32].
- m_be  in  NUM_MASTERS*4  byte enables, flattened; master i uses bits [i*4 +: 4].
- m_wdata  in  NUM_MASTERS*32  write data, flattened; master i uses bits [i*32 +: 32].
- m_ack  out  NUM_MASTERS  request accepted this cycle; one-hot or zero.
- m_resp  out  NUM_MASTERS  read data valid this cycle; one-hot or zero.
- m_rdata  out  32  read data, broadcast to all masters; valid only where m_resp is set.
- s_req, s_we, s_addr[31:0], s_be[3:0], s_wdata[31:0]  out  request to the slave.
- s_ack  in  1  slave accepts this cycle.
- s_resp  in  1  slave read response valid. Responses arrive in order, at least 1 cycle after the ack.
- s_rdata  in  32  slave read data.
- err_o  out  1  sticky flag, set by a response with no outstanding read; cleared only by reset.

## Operation
- Grant is a combinational round-robin choice among set m_req bits, starting at index rr_ptr and searching upward with wrap-around. gnt is one-hot or zero.
- s_req = (|m_req) & !fifo_full. The s_we/s_addr/s_be/s_wdata fields are muxed from the granted master. When no master is granted the fields are driven to 0.
- m_ack[g] = s_req & s_ack & gnt[g]. A master that is not granted keeps its request held with no other effect.
- An accepted transfer (s_req & s_ack) sets rr_ptr to (g+1) mod NUM_MASTERS. Without an accepted transfer, rr_ptr is held.
- An accepted read (s_we = 0) pushes g into the ID FIFO. Accepted writes do not push.
- On s_resp with the FIFO not empty: pop the head h, set m_resp[h] = 1, and set m_rdata = s_rdata.
- On s_resp with the FIFO empty: m_resp stays 0, err_o is set, and the FIFO is unchanged.
- Push and pop in the same cycle is legal and leaves the count unchanged.
- fifo_full (count == MAX_OUTSTANDING) blocks all new requests, writes included, to keep ordering simple. s_resp does not unblock the same cycle; the block releases on the next cycle.
- A master whose request is never acked under a permanent fifo_full is not an arbiter fault. Starvation freedom holds whenever the slave keeps acking.

## Timing
- Reset values: rr_ptr = 0, FIFO empty (rd/wr pointers and count = 0), err_o = 0. All other outputs are combinational and follow from these values: m_ack = 0 and m_resp = 0 when the inputs are idle.
- Request path: zero added latency, combinational from m_req to s_req and from s_ack to m_ack.
- Response path: zero added latency, combinational from s_resp to m_resp, selected by the registered FIFO head.
- Fairness: with all masters requesting continuously and s_ack = 1, the grant order is 0, 1, …, N-1, 0 and so on. Each master gets one transfer per N cycles.
- Reset mid-operation clears the FIFO. A response arriving afterwards for a pre-reset read sets err_o. The environment must quiesce the slave before reset to avoid this.
- Pointer and count arithmetic: pointers are clog2(MAX_OUTSTANDING) bits and wrap naturally. count is clog2(MAX_OUTSTANDING)+1 bits.

## Structure
- Shared package magma_bus_pkg: BUS_AW = 32, BUS_DW = 32, BUS_BEW = 4, and the packed bus request struct type. The same package is used by sfr and the other cluster slaves.
- One sub-module, magma_arb_idfifo: a synchronous FIFO of clog2(NUM_MASTERS)-bit entries with full/empty outputs, registered head, and asynchronous reset.
- Round-robin priority logic stays inline: a double-width request vector, rotated, followed by a priority encoder.

## Test plan
- Single master: master 2 reads addr 0x10. Required: m_ack[2] in the same cycle as s_ack. When s_resp arrives with s_rdata = 0xCAFE, m_resp = 4'b0100 and m_rdata = 0xCAFE.
- All four masters request continuously with s_ack = 1. Required: grants 0, 1, 2, 3, 0, 1 on consecutive cycles, and rr_ptr follows.
- Interleaved reads from masters 3, 1, 0 with responses delayed by 3 cycles. Required: m_resp one-hot in order 1000, 0010, 0001.
- Four reads outstanding with MAX_OUTSTANDING = 4. Required: s_req = 0 while master 1 requests. One cycle after the first s_resp, s_req = 1 and master 1 is acked.
- s_resp while the FIFO is empty. Required: m_resp = 0 and err_o = 1, holding until rst_i. With s_ack = 0, a held request gets no m_ack and rr_ptr does not change.
- Assert rst_i asynchronously, mid-cycle, with two reads outstanding. Required: count = 0, rr_ptr = 0 and err_o = 0 immediately, without waiting for a clock edge.
